ps2_key_decoder: RTL and testbench
==================================

// Module: ps2_key_decoder
// PURPOSE
//  Clocked, parametrised successor to the fixed-key PS/2 keyboard decoder. Consumes the byte stream
//  from mouse_Inner_controller (received_data / received_data_en) and decodes the make, break (F0)
//  and extended (E0) prefixes. For NUM_KEYS programmable scan codes it maintains held-key state and
//  per-key press/release pulses. Mapped events are queued in a small valid/ready FIFO for game logic.
// PARAMETERS
//  NUM_KEYS       6           number of mapped keys (1..32)
//  KEY_CODES      {9'h075,9'h072,9'h06B,9'h074,9'h029,9'h05A}  packed {ext,code} per key; key i at [9i+8:9i]
//                             (default lists key5..key0: key0=enter, key1=space, key2=right, key3=left, key4=down, key5=up)
//  FIFO_DEPTH     8           event FIFO entries, power of 2, >=2
//  TIMEOUT_CYCLES 50_000_000  idle cycles after a prefix byte before the prefix is discarded (>=2)
// PORTS
//  CLOCK        in   1                  system clock
//  reset_n      in   1                  asynchronous active-low reset
//  rx_data      in   8                  received byte, valid when rx_valid=1
//  rx_valid     in   1                  one-cycle strobe, synchronous to CLOCK
//  key_state    out  NUM_KEYS           1 = key held
//  key_press    out  NUM_KEYS           one-cycle pulse on a make event for the key
//  key_release  out  NUM_KEYS           one-cycle pulse on a break event for the key
//  evt_valid    out  1                  FIFO head valid
//  evt_ready    in   1                  consumer accepts head when evt_valid & evt_ready
//  evt_idx      out  $clog2(NUM_KEYS)   key index of head event (width 1 when NUM_KEYS=1)
//  evt_break    out  1                  head is a release (1) or press (0)
//  evt_overflow out  1                  sticky: an event was dropped because the FIFO was full
//  ovf_clr      in   1                  clears evt_overflow; a same-cycle drop wins, flag stays 1
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, FIFO empty, timeout counter 0.
//  FSM (advances only on rx_valid, except on timeout):
//   IDLE:    E0->EXT, F0->BRK, other b -> make{0,b}, stay.
//   EXT:     F0->EXTBRK, E0->EXT, other b -> make{1,b} -> IDLE.
//   BRK:     E0/F0 -> IDLE, byte discarded; other b -> break{0,b} -> IDLE.
//   EXTBRK:  E0/F0 -> IDLE, byte discarded; other b -> break{1,b} -> IDLE.
//  Control bytes: AA (BAT ok), FC, 00, FF in any state -> clear key_state, no pulses/events, FSM=IDLE.
//  Timeout: in a non-IDLE state the counter increments each cycle without rx_valid and is 0 otherwise;
//   at TIMEOUT_CYCLES-1 the FSM returns to IDLE and the counter clears.
//  Decode: a {ext,code} matching KEY_CODES entry i sets (make) or clears (break) key_state[i].
//   Duplicate entries resolve to the lowest i. Unmapped codes: no effect.
//  Latency: rx_valid at cycle N -> key_state, pulses and FIFO push at N+1; evt_valid at N+1 when the
//   FIFO was empty (no bypass of registered storage beyond that).
//  FIFO: push on every mapped event. A pop when full frees the slot for a same-cycle push. A push
//   when full with no pop drops the new event and sets evt_overflow. evt_idx and evt_break are
//   stable while evt_valid & !evt_ready.
//  Break for a key not held: key_release still pulses and the event is queued (auto-repeat lost sync).
// CONFIGURATION
//  PS2_TYPEMATIC_FILTER_EN defined: a make for a key already held updates nothing, with no
//   key_press pulse and no event, which suppresses keyboard auto-repeat.
//  Not defined: every make, including repeats, pulses key_press[i] and pushes a press event.
// TESTING
//  1 bytes 29 ; F0,29 -> key_state[1] 1 then 0; key_press[1] and key_release[1] pulse once each;
//    FIFO holds {1,press},{1,release}.
//  2 bytes E0,75 ; E0,F0,75 -> key_state[5] set then cleared; bare 75 alone leaves key_state unchanged.
//  3 E0, then no byte for TIMEOUT_CYCLES (set 16 in bench), then 5A -> non-extended make,
//    key_state[0]=1 (prefix discarded).
//  4 evt_ready=0, 9 makes with FIFO_DEPTH=8 -> 8 queued, evt_overflow=1; ovf_clr -> flag 0;
//    full FIFO with push+pop in the same cycle -> no drop.
//  5 three 29 makes -> filter on: 1 event and 1 pulse; filter off: 3 events and 3 pulses.
//  6 hold 5A and 29, send AA -> key_state=0 with no events; reset_n low mid-prefix -> IDLE,
//    outputs 0 asynchronously.

Source files
------------

// File: rtl/ps2_key_decoder.sv
// PS/2 scan-code decoder: make/break/extended prefixes, per-key held state and pulses, event FIFO.
// Optional PS2_TYPEMATIC_FILTER_EN: ignore makes of keys already held (drops auto-repeat).
module ps2_key_decoder #(
    parameter int                    NUM_KEYS       = 6,
    parameter logic [9*NUM_KEYS-1:0] KEY_CODES      = {9'h075, 9'h072, 9'h06B, 9'h074, 9'h029, 9'h05A},
    parameter int                    FIFO_DEPTH     = 8,
    parameter int                    TIMEOUT_CYCLES = 50_000_000,
    localparam int                   IDX_W          = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1
) (
    input  logic                CLOCK,
    input  logic                reset_n,
    input  logic [7:0]          rx_data,
    input  logic                rx_valid,
    output logic [NUM_KEYS-1:0] key_state,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic                evt_valid,
    input  logic                evt_ready,
    output logic [IDX_W-1:0]    evt_idx,
    output logic                evt_break,
    output logic                evt_overflow,
    input  logic                ovf_clr
);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, EXT, BRK, EXTBRK} state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             ev_fire, ev_brk, ev_ext, ctrl_clr, is_ctrl;
    logic             hit, repeat_make, push;
    logic [IDX_W-1:0] hit_idx;

    assign is_ctrl = (rx_data == 8'hAA) || (rx_data == 8'hFC) ||
                     (rx_data == 8'h00) || (rx_data == 8'hFF);

    always_ff @(posedge CLOCK or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n  = state;
        cnt_n    = '0;
        ev_fire  = 1'b0;
        ev_brk   = 1'b0;
        ev_ext   = 1'b0;
        ctrl_clr = 1'b0;
        if (rx_valid) begin
            if (is_ctrl) begin
                ctrl_clr = 1'b1;
                state_n  = IDLE;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (rx_data == 8'hE0)      state_n = EXT;
                        else if (rx_data == 8'hF0) state_n = BRK;
                        else                       ev_fire = 1'b1;
                    end
                    EXT: begin
                        if (rx_data == 8'hF0)      state_n = EXTBRK;
                        else if (rx_data == 8'hE0) state_n = EXT;
                        else begin
                            ev_fire = 1'b1;
                            ev_ext  = 1'b1;
                            state_n = IDLE;
                        end
                    end
                    BRK: begin
                        state_n = IDLE;
                        ev_fire = (rx_data != 8'hE0) && (rx_data != 8'hF0);
                        ev_brk  = 1'b1;
                    end
                    EXTBRK: begin
                        state_n = IDLE;
                        ev_fire = (rx_data != 8'hE0) && (rx_data != 8'hF0);
                        ev_brk  = 1'b1;
                        ev_ext  = 1'b1;
                    end
                    default: state_n = IDLE;
                endcase
            end
        end else if (state != IDLE) begin
            // A dangling prefix is abandoned after a long idle gap
            if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) state_n = IDLE;
            else                                   cnt_n   = cnt + 1'b1;
        end
    end

    // Descending scan so the lowest matching index wins
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (KEY_CODES[9*i +: 9] == {ev_ext, rx_data}) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end
        end
    end

`ifdef PS2_TYPEMATIC_FILTER_EN
    assign repeat_make = !ev_brk && key_state[hit_idx];
`else
    assign repeat_make = 1'b0;
`endif

    assign push = ev_fire && hit && !repeat_make;

    always_ff @(posedge CLOCK or negedge reset_n) begin
        if (!reset_n) begin
            key_state   <= '0;
            key_press   <= '0;
            key_release <= '0;
        end else begin
            key_press   <= '0;
            key_release <= '0;
            if (ctrl_clr) begin
                key_state <= '0;
            end else if (push) begin
                key_state[hit_idx]   <= !ev_brk;
                key_press[hit_idx]   <= !ev_brk;
                key_release[hit_idx] <= ev_brk;
            end
        end
    end

    // Event FIFO: entry = {idx, break}
    logic [IDX_W:0]   mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W:0]   count;
    logic             full, pop, do_push, drop;

    assign full      = (count == (PTR_W + 1)'(FIFO_DEPTH));
    assign evt_valid = (count != '0);
    assign pop       = evt_valid && evt_ready;
    assign do_push   = push && (!full || pop);
    assign drop      = push && full && !pop;
    assign evt_idx   = mem[rd_ptr][IDX_W:1];
    assign evt_break = mem[rd_ptr][0];

    always_ff @(posedge CLOCK or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            evt_overflow <= 1'b0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= {hit_idx, ev_brk};
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (drop)         evt_overflow <= 1'b1;
            else if (ovf_clr) evt_overflow <= 1'b0;
        end
    end
endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder; arrow keys mapped as extended codes, short timeout.
module tb_ps2_key_decoder;
    localparam int NK = 6;
`ifdef PS2_TYPEMATIC_FILTER_EN
    localparam bit FILT = 1'b1;
`else
    localparam bit FILT = 1'b0;
`endif

    logic          CLOCK, reset_n;
    logic [7:0]    rx_data;
    logic          rx_valid, evt_ready, ovf_clr;
    logic [NK-1:0] key_state, key_press, key_release;
    logic          evt_valid, evt_break, evt_overflow;
    logic [2:0]    evt_idx;

    int n_assert = 0;
    int n_fail   = 0;

    ps2_key_decoder #(
        .NUM_KEYS(NK),
        .KEY_CODES({9'h175, 9'h172, 9'h16B, 9'h174, 9'h029, 9'h05A}),
        .FIFO_DEPTH(8),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .CLOCK(CLOCK), .reset_n(reset_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .key_state(key_state), .key_press(key_press), .key_release(key_release),
        .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_idx(evt_idx),
        .evt_break(evt_break), .evt_overflow(evt_overflow), .ovf_clr(ovf_clr)
    );

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Byte strobe for one cycle; returns at the negedge where its effects are visible
    task automatic send(input logic [7:0] b);
        @(negedge CLOCK);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge CLOCK);
        rx_valid = 1'b0;
    endtask

    task automatic pop_chk(input string tag, input logic [2:0] idx, input logic brk);
        chk({tag, "_valid"}, evt_valid, 1'b1);
        chk({tag, "_idx"}, evt_idx, idx);
        chk({tag, "_brk"}, evt_break, brk);
        evt_ready = 1'b1;
        @(negedge CLOCK);
        evt_ready = 1'b0;
    endtask

    initial begin
        reset_n = 1'b1; rx_data = 8'h00; rx_valid = 1'b0; evt_ready = 1'b0; ovf_clr = 1'b0;
        #2 reset_n = 1'b0;
        #20;
        chk("rst_state", key_state, 0);
        chk("rst_press", key_press, 0);
        chk("rst_valid", evt_valid, 0);
        chk("rst_ovf", evt_overflow, 0);
        @(negedge CLOCK) reset_n = 1'b1;

        // 1: plain make / break of key1
        send(8'h29);
        chk("t1_state_m", key_state, 6'b000010);
        chk("t1_press", key_press, 6'b000010);
        chk("t1_rel0", key_release, 0);
        send(8'hF0);
        chk("t1_state_pfx", key_state, 6'b000010);
        send(8'h29);
        chk("t1_state_b", key_state, 0);
        chk("t1_release", key_release, 6'b000010);
        chk("t1_press0", key_press, 0);
        pop_chk("t1_e0", 3'd1, 1'b0);
        pop_chk("t1_e1", 3'd1, 1'b1);
        chk("t1_empty", evt_valid, 0);

        // 2: extended make / break of key5; bare code is unmapped
        send(8'hE0); send(8'h75);
        chk("t2_state_m", key_state, 6'b100000);
        chk("t2_press", key_press, 6'b100000);
        send(8'hE0); send(8'hF0); send(8'h75);
        chk("t2_state_b", key_state, 0);
        chk("t2_release", key_release, 6'b100000);
        send(8'h75);
        chk("t2_bare", key_state, 0);
        chk("t2_bare_p", key_press, 0);
        pop_chk("t2_e0", 3'd5, 1'b0);
        pop_chk("t2_e1", 3'd5, 1'b1);
        chk("t2_empty", evt_valid, 0);

        // 3: prefix survives a short gap, is discarded after a long one
        send(8'hE0);
        repeat (10) @(negedge CLOCK);
        send(8'h72);
        chk("t3_short", key_state, 6'b010000);
        send(8'hE0);
        repeat (20) @(negedge CLOCK);
        send(8'h5A);
        chk("t3_timeout", key_state, 6'b010001);
        chk("t3_press", key_press, 6'b000001);
        pop_chk("t3_e0", 3'd4, 1'b0);
        pop_chk("t3_e1", 3'd0, 1'b0);

        // 4: fill FIFO, overflow (drop beats clear), clear, push+pop when full
        for (int i = 0; i < 4; i++) begin
            send(8'h29); send(8'hF0); send(8'h29);
        end
        chk("t4_full_noovf", evt_overflow, 0);
        @(negedge CLOCK);
        rx_data = 8'h29; rx_valid = 1'b1; ovf_clr = 1'b1;
        @(negedge CLOCK);
        rx_valid = 1'b0; ovf_clr = 1'b0;
        chk("t4_ovf_set", evt_overflow, 1);
        chk("t4_state_drop", key_state, 6'b010011);
        ovf_clr = 1'b1;
        @(negedge CLOCK);
        ovf_clr = 1'b0;
        chk("t4_ovf_clr", evt_overflow, 0);
        send(8'hF0);
        rx_data = 8'h29; rx_valid = 1'b1; evt_ready = 1'b1;
        @(negedge CLOCK);
        rx_valid = 1'b0; evt_ready = 1'b0;
        chk("t4_pushpop", evt_overflow, 0);
        for (int i = 0; i < 8; i++)
            pop_chk($sformatf("t4_d%0d", i), 3'd1, (i == 7) ? 1'b1 : 1'(i % 2 == 0));
        chk("t4_empty", evt_valid, 0);

        // 5: auto-repeat makes
        send(8'h29);
        chk("t5_p0", key_press, 6'b000010);
        send(8'h29);
        chk("t5_p1", key_press, FILT ? 6'b0 : 6'b000010);
        send(8'h29);
        chk("t5_p2", key_press, FILT ? 6'b0 : 6'b000010);
        for (int i = 0; i < (FILT ? 1 : 3); i++)
            pop_chk($sformatf("t5_e%0d", i), 3'd1, 1'b0);
        chk("t5_empty", evt_valid, 0);

        // 6: BAT control byte clears held keys without events; async reset mid-prefix
        chk("t6_held", key_state, 6'b010011);
        send(8'hAA);
        chk("t6_aa_state", key_state, 0);
        chk("t6_aa_rel", key_release, 0);
        chk("t6_aa_evt", evt_valid, 0);
        send(8'h29);
        send(8'hE0);
        chk("t6_pre_q", evt_valid, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("t6_rst_state", key_state, 0);
        chk("t6_rst_evt", evt_valid, 0);
        @(negedge CLOCK) reset_n = 1'b1;
        send(8'h75);
        chk("t6_idle_after", key_state, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
